alu_result_display: RTL and testbench

ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

---
 rtl/alu_result_display.sv | 115 +++++++++++
 tb/tb_alu_result_display.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// Latches a 4-bit multiplier result and its Z/N/C/V flags and scans them onto a 4-digit
// active-low 7-segment display. Optional macro SIGNED_VIEW_EN selects a two's-complement view of digit0/digit1.
module alu_result_display #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] result,
   input  logic       flag_z,
   input  logic       flag_n,
   input  logic       flag_c,
   input  logic       flag_v,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic [3:0] leds,
   output logic       valid
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_U     = 7'h41;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [3:0]       r_res;
   logic [3:0]       r_flags;   // {V,C,N,Z}
   logic             r_valid;

   logic [3:0]       w_dig0_val;
   logic [6:0]       w_dig0_seg;
   logic [6:0]       w_dig1_seg;
   logic [6:0]       w_seg;

   // Standard hex glyphs, active-low {g,f,e,d,c,b,a}, lowercase b and d.
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Refresh counter, digit index and capture latches; a load never disturbs the scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_res   <= 4'd0;
         r_flags <= 4'd0;
         r_valid <= 1'b0;
      end else begin
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (load) begin
            r_res   <= result;
            r_flags <= {flag_v, flag_c, flag_n, flag_z};
            r_valid <= 1'b1;
         end
      end
   end

`ifdef SIGNED_VIEW_EN
   // Magnitude of the two's-complement value; 4'b1000 wraps to itself and reads as 8.
   assign w_dig0_val = r_res[3] ? 4'(~r_res + 4'd1) : r_res;
   assign w_dig1_seg = r_res[3] ? SEG_DASH : SEG_BLANK;
`else
   assign w_dig0_val = r_res;
   assign w_dig1_seg = SEG_BLANK;
`endif

   assign w_dig0_seg = hex_glyph(w_dig0_val);

   // Segment decode from registered state only.
   always_comb begin
      w_seg = SEG_BLANK;
      if (r_valid) begin
         case (r_idx)
            2'd0:    w_seg = w_dig0_seg;
            2'd1:    w_seg = w_dig1_seg;
            2'd2:    w_seg = r_flags[2] ? SEG_C : SEG_BLANK;
            default: w_seg = r_flags[3] ? SEG_U : SEG_BLANK;
         endcase
      end
   end

   assign seg   = w_seg;
   assign an    = ~(4'b0001 << r_idx);
   assign leds  = r_flags;
   assign valid = r_valid;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display (REFRESH_DIV=4), comparing every cycle against
// a cycle-count based model; directed scenarios plus a randomized phase.
module tb_alu_result_display;

   localparam int unsigned DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] result;
   logic       flag_z, flag_n, flag_c, flag_v;
   logic [6:0] seg;
   logic [3:0] an;
   logic [3:0] leds;
   logic       valid;

   int checks   = 0;
   int failures = 0;

   alu_result_display #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .load(load), .result(result),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
      .seg(seg), .an(an), .leds(leds), .valid(valid)
   );

   always #5 clk = ~clk;

   // Model: elapsed edges since reset plus the last captured values.
   int         m_cyc;
   logic [3:0] m_res;
   logic [3:0] m_flags;
   logic       m_valid;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc   <= 0;
         m_res   <= 4'd0;
         m_flags <= 4'd0;
         m_valid <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (load) begin
            m_res   <= result;
            m_flags <= {flag_v, flag_c, flag_n, flag_z};
            m_valid <= 1'b1;
         end
      end
   end

   logic [6:0] glyph [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic int model_idx();
      return (m_cyc / DIV) % 4;
   endfunction

   function automatic logic [3:0] model_an();
      logic [3:0] one;
      one = 4'b0001 << model_idx();
      return 4'b1111 ^ one;
   endfunction

   function automatic logic [6:0] model_seg();
      int v;
      if (!m_valid) return 7'h7F;
      case (model_idx())
`ifdef SIGNED_VIEW_EN
         0: begin
            v = (m_res >= 8) ? 16 - int'(m_res) : int'(m_res);
            return glyph[v];
         end
         1: return (m_res >= 8) ? 7'h3F : 7'h7F;
`else
         0: return glyph[m_res];
         1: return 7'h7F;
`endif
         2: return m_flags[2] ? 7'h46 : 7'h7F;
         default: return m_flags[3] ? 7'h41 : 7'h7F;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Continuous compare against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cmp_an",    8'(an),    8'(model_an()));
      chk("cmp_seg",   8'(seg),   8'(model_seg()));
      chk("cmp_leds",  8'(leds),  8'(m_flags));
      chk("cmp_valid", 8'(valid), 8'(m_valid));
   end

   task automatic wait_digit(input int k);
      logic [3:0] want;
      bit found;
      want = 4'b1111 ^ (4'b0001 << k);
      found = 0;
      for (int n = 0; n < 40; n++) begin
         if (an === want) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      if (!found) begin
         failures++;
         $display("FAIL wait_digit%0d: timeout, an=%b", k, an);
      end
   endtask

   // Wait for a negedge at a given digit and counter phase (m_cyc % DIV).
   task automatic wait_phase(input int k, input int ph);
      bit found;
      found = 0;
      for (int n = 0; n < 40; n++) begin
         if (model_idx() == k && (m_cyc % DIV) == ph) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      if (!found) begin
         failures++;
         $display("FAIL wait_phase%0d_%0d: timeout", k, ph);
      end
   endtask

   task automatic do_load(input logic [3:0] r, input logic [3:0] vcnz);
      load   = 1'b1;
      result = r;
      {flag_v, flag_c, flag_n, flag_z} = vcnz;
   endtask

   logic [3:0] walk [0:4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

   initial begin
      rst = 1'b1;
      load = 1'b0;
      result = 4'd0;
      {flag_v, flag_c, flag_n, flag_z} = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_an", 8'(an), 8'h0E);
      chk("rst_seg", 8'(seg), 8'h7F);
      chk("rst_leds", 8'(leds), 8'h00);
      chk("rst_valid", 8'(valid), 8'h00);
      rst = 1'b0;

      // Scan walk with nothing loaded.
      for (int i = 0; i < 5; i++) begin
         chk("walk_an", 8'(an), 8'(walk[i]));
         chk("walk_seg", 8'(seg), 8'h7F);
         repeat (DIV) @(negedge clk);
      end

      // Load F with C=1,N=1; leds are {V,C,N,Z}.
      do_load(4'hF, 4'b0110);
      @(negedge clk);
      load = 1'b0;
      chk("ld_valid", 8'(valid), 8'h01);
      chk("ld_leds", 8'(leds), 8'h06);
      wait_digit(0);
`ifdef SIGNED_VIEW_EN
      chk("ldF_d0", 8'(seg), 8'h79);
      wait_digit(1);
      chk("ldF_d1", 8'(seg), 8'h3F);
`else
      chk("ldF_d0", 8'(seg), 8'h0E);
      wait_digit(1);
      chk("ldF_d1", 8'(seg), 8'h7F);
`endif
      wait_digit(2);
      chk("ldF_d2", 8'(seg), 8'h46);
      wait_digit(3);
      chk("ldF_d3", 8'(seg), 8'h7F);

      // Asynchronous reset mid-scan, checked between clock edges.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_an", 8'(an), 8'h0E);
      chk("arst_seg", 8'(seg), 8'h7F);
      chk("arst_leds", 8'(leds), 8'h00);
      chk("arst_valid", 8'(valid), 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Load coinciding with terminal count of digit3.
      do_load(4'hA, 4'b1000);
      @(negedge clk);
      load = 1'b0;
      wait_phase(3, DIV - 1);
      do_load(4'h0, 4'b0000);
      @(negedge clk);
      load = 1'b0;
      chk("tc_an", 8'(an), 8'h0E);
      chk("tc_seg", 8'(seg), 8'h40);
      repeat (DIV - 1) begin
         @(negedge clk);
         chk("tc_hold_an", 8'(an), 8'h0E);
      end
      @(negedge clk);
      chk("tc_next_an", 8'(an), 8'h0D);

      // Back-to-back loads within one digit0 slot.
      wait_phase(0, 0);
      do_load(4'h8, 4'b0101);
      @(negedge clk);
      do_load(4'h0, 4'b1010);
      chk("b2b_seg8", 8'(seg), 8'h00);
      chk("b2b_leds8", 8'(leds), 8'h05);
      @(negedge clk);
      load = 1'b0;
      chk("b2b_seg0", 8'(seg), 8'h40);
      chk("b2b_leds0", 8'(leds), 8'h0A);
      chk("b2b_an", 8'(an), 8'h0E);

`ifdef SIGNED_VIEW_EN
      wait_phase(0, 0);
      do_load(4'b1101, 4'b0010);
      @(negedge clk);
      load = 1'b0;
      chk("sgn_d0_m3", 8'(seg), 8'h30);
      wait_digit(1);
      chk("sgn_d1_m3", 8'(seg), 8'h3F);
      wait_phase(0, 0);
      do_load(4'b1000, 4'b0010);
      @(negedge clk);
      load = 1'b0;
      chk("sgn_d0_m8", 8'(seg), 8'h00);
      wait_digit(1);
      chk("sgn_d1_m8", 8'(seg), 8'h3F);
`endif

      // Randomized phase with occasional asynchronous resets.
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) begin
            load = 1'b0;
            #1 rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
         end else begin
            load   = ($urandom_range(0, 3) == 0);
            result = 4'($urandom);
            {flag_v, flag_c, flag_n, flag_z} = 4'($urandom);
         end
      end
      load = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
